// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and gap-free back-to-back frames.
// Optional even-parity bit appended after the data when PISO_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 0,
   parameter int DIV       = 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int BW = $clog2(WIDTH + 1);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
   localparam logic [BW-1:0] PRE_LAST = BW'(N - 2);
   localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_next;
   logic [BW-1:0]    r_bit_cnt;
   logic [BW-1:0]    w_bit_cnt_next;
   logic [DW-1:0]    r_div_cnt;
   logic [DW-1:0]    w_div_cnt_next;
   logic             r_ser_out;
   logic             w_ser_out_next;
   logic             r_ser_valid;
   logic             w_ser_valid_next;
   logic             r_ser_last;
   logic             w_ser_last_next;
   logic             r_done;
   logic             w_done_next;

   logic             w_first_bit;
   logic             w_next_bit;
   logic             w_next_emit;
   logic [WIDTH-1:0] w_load_rem;
   logic [WIDTH-1:0] w_adv_rem;
   logic             w_div_end;
   logic             w_final;
   logic             w_accept;

   // r_shift holds only the bits not yet presented; the current bit lives in r_ser_out.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_first_bit = in_data[WIDTH-1];
         assign w_load_rem  = {in_data[WIDTH-2:0], 1'b0};
         assign w_next_bit  = r_shift[WIDTH-1];
         assign w_adv_rem   = {r_shift[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_first_bit = in_data[0];
         assign w_load_rem  = {1'b0, in_data[WIDTH-1:1]};
         assign w_next_bit  = r_shift[0];
         assign w_adv_rem   = {1'b0, r_shift[WIDTH-1:1]};
      end
   endgenerate

`ifdef PISO_PARITY_EN
   logic r_parity;
   logic w_parity_next;

   // Parity takes the slot after the last data bit.
   assign w_next_emit = (r_bit_cnt == PRE_LAST) ? r_parity : w_next_bit;
`else
   assign w_next_emit = w_next_bit;
`endif

   assign w_div_end = (r_div_cnt == DIV_MAX);
   assign w_final   = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT) && w_div_end;
   assign in_ready  = (r_state == S_IDLE) || w_final;
   assign w_accept  = in_valid && in_ready;

   always_comb begin
      w_state_next     = r_state;
      w_shift_next     = r_shift;
      w_bit_cnt_next   = r_bit_cnt;
      w_div_cnt_next   = r_div_cnt;
      w_ser_out_next   = r_ser_out;
      w_ser_valid_next = r_ser_valid;
      w_ser_last_next  = r_ser_last;
      w_done_next      = 1'b0;
`ifdef PISO_PARITY_EN
      w_parity_next    = r_parity;
`endif

      if (w_accept) begin
         w_state_next     = S_SHIFT;
         w_shift_next     = w_load_rem;
         w_bit_cnt_next   = '0;
         w_div_cnt_next   = '0;
         w_ser_out_next   = w_first_bit;
         w_ser_valid_next = 1'b1;
         w_ser_last_next  = 1'b0;
`ifdef PISO_PARITY_EN
         w_parity_next    = ^in_data;
`endif
      end

      case (r_state)
         S_IDLE: begin
         end
         S_SHIFT: begin
            if (w_div_end) begin
               if (r_bit_cnt == LAST_BIT) begin
                  w_done_next = 1'b1;
                  if (!w_accept) begin
                     w_state_next     = S_IDLE;
                     w_shift_next     = '0;
                     w_bit_cnt_next   = '0;
                     w_div_cnt_next   = '0;
                     w_ser_out_next   = 1'b0;
                     w_ser_valid_next = 1'b0;
                     w_ser_last_next  = 1'b0;
                  end
               end else begin
                  w_bit_cnt_next  = r_bit_cnt + 1'b1;
                  w_div_cnt_next  = '0;
                  w_shift_next    = w_adv_rem;
                  w_ser_out_next  = w_next_emit;
                  w_ser_last_next = (r_bit_cnt == PRE_LAST);
               end
            end else begin
               w_div_cnt_next = r_div_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_div_cnt   <= '0;
         r_ser_out   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_ser_last  <= 1'b0;
         r_done      <= 1'b0;
`ifdef PISO_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_shift     <= w_shift_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_div_cnt   <= w_div_cnt_next;
         r_ser_out   <= w_ser_out_next;
         r_ser_valid <= w_ser_valid_next;
         r_ser_last  <= w_ser_last_next;
         r_done      <= w_done_next;
`ifdef PISO_PARITY_EN
         r_parity    <= w_parity_next;
`endif
      end
   end

   assign ser_out   = r_ser_out;
   assign ser_valid = r_ser_valid;
   assign ser_last  = r_ser_last;
   assign busy      = r_ser_valid;
   assign done      = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (LSB/DIV1, MSB/DIV1, LSB/DIV3) share stimulus;
// expected bits are queued at accept and popped by a negedge monitor on the selected instance.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [2:0]   rdy, so, sv, sl, bz, dn;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   sel = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .DIV(1)) u_lsb (
      .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
      .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0]), .done(dn[0]));
   piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .DIV(1)) u_msb (
      .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
      .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1]), .done(dn[1]));
   piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .DIV(3)) u_div3 (
      .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
      .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .busy(bz[2]), .done(dn[2]));

   // Serial-stream monitor: every valid cycle consumes one queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         checks++;
         if (bz[sel] !== sv[sel]) begin
            errors++;
            $display("FAIL busy_eq_valid dut=%0d busy=%b ser_valid=%b", sel, bz[sel], sv[sel]);
         end
         checks++;
         if (sv[sel] === 1'b1) begin
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_bit dut=%0d t=%0t ser_out=%b expected no frame bit", sel, $time, so[sel]);
            end else begin
               e = sbq.pop_front();
               if ({so[sel], sl[sel]} !== {e.b, e.l}) begin
                  errors++;
                  $display("FAIL serial_bit dut=%0d t=%0t out/last=%b%b expected %b%b",
                           sel, $time, so[sel], sl[sel], e.b, e.l);
               end else begin
                  $display("bit dut=%0d t=%0t out=%b last=%b", sel, $time, so[sel], sl[sel]);
               end
            end
         end else if ({so[sel], sl[sel]} !== 2'b00) begin
            errors++;
            $display("FAIL idle_outputs dut=%0d out/last=%b%b expected 00", sel, so[sel], sl[sel]);
         end
      end
   end

   task automatic push_frame(input logic [W-1:0] w, input bit msb, input int d);
      exp_t e;
      for (int k = 0; k < NB; k++) begin
         if (k == W) e.b = ^w;
         else        e.b = msb ? w[W-1-k] : w[k];
         e.l = (k == NB - 1);
         for (int j = 0; j < d; j++) sbq.push_back(e);
      end
   endtask

   task automatic do_reset(input int sel_i);
      mon_en = 1'b0;
      #1 sel = sel_i;
      @(negedge clk);
      #2 rst_b = 1'b0;
      in_valid = 1'b0;
      sbq.delete();
      @(negedge clk);
      #2 rst_b = 1'b1;
      mon_en = 1'b1;
   endtask

   // Accept one word at edge T and check valid/done/ready timing for cycles T+1 .. T+N*d+1.
   task automatic run_frame(input int sel_i, input logic [W-1:0] w, input bit msb, input int d);
      bit ev, ed, er;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      push_frame(w, msb, d);
      @(posedge clk);
      for (int k = 1; k <= NB * d + 1; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         ev = (k <= NB * d);
         ed = (k == NB * d + 1);
         er = (k >= NB * d);
         checks++;
         if ({sv[sel_i], dn[sel_i], rdy[sel_i]} !== {ev, ed, er}) begin
            errors++;
            $display("FAIL frame_timing dut=%0d word=%h cyc=T+%0d valid/done/ready=%b%b%b expected %b%b%b",
                     sel_i, w, k, sv[sel_i], dn[sel_i], rdy[sel_i], ev, ed, er);
         end
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL frame_complete dut=%0d word=%h leftover=%0d expected 0", sel_i, w, sbq.size());
      end else begin
         $display("frame dut=%0d word=%h div=%0d done", sel_i, w, d);
      end
   endtask

   task automatic test_reset();
      mon_en = 1'b0;
      @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({so[s], sv[s], sl[s], bz[s], dn[s], rdy[s]} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_state dut=%0d out/valid/last/busy/done/ready=%b%b%b%b%b%b expected 000001",
                     s, so[s], sv[s], sl[s], bz[s], dn[s], rdy[s]);
         end
      end
      @(negedge clk);
      #2 rst_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({sv, dn, rdy} !== 9'b000_000_111) begin
            errors++;
            $display("FAIL idle_state valid=%b done=%b ready=%b expected 000 000 111", sv, dn, rdy);
         end
      end
      $display("reset checked");
   endtask

   task automatic test_lsb();
      do_reset(0);
      run_frame(0, 8'hC4, 1'b0, 1);
      for (int i = 0; i < 3; i++) run_frame(0, 8'($urandom), 1'b0, 1);
   endtask

   task automatic test_msb();
      do_reset(1);
      run_frame(1, 8'hC4, 1'b1, 1);
      run_frame(1, 8'h01, 1'b1, 1);
   endtask

   task automatic test_div3();
      do_reset(2);
      run_frame(2, 8'hC4, 1'b0, 3);
      run_frame(2, 8'h80, 1'b0, 3);
   endtask

   task automatic test_back_to_back();
      bit ev, ed, er;
      do_reset(0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hC4;
      push_frame(8'hC4, 1'b0, 1);
      push_frame(8'h5A, 1'b0, 1);
      @(posedge clk);
      for (int k = 1; k <= 2 * NB + 1; k++) begin
         @(negedge clk);
         ev = (k <= 2 * NB);
         ed = (k == NB + 1) || (k == 2 * NB + 1);
         er = (k == NB) || (k >= 2 * NB);
         checks++;
         if ({sv[0], dn[0], rdy[0]} !== {ev, ed, er}) begin
            errors++;
            $display("FAIL b2b_timing cyc=T+%0d valid/done/ready=%b%b%b expected %b%b%b",
                     k, sv[0], dn[0], rdy[0], ev, ed, er);
         end
         if (k == NB + 1) begin
            checks++;
            if ({so[0], dn[0]} !== 2'b01) begin
               errors++;
               $display("FAIL b2b_first_bit out/done=%b%b expected 01", so[0], dn[0]);
            end
         end
         if (k < NB) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end else if (k == NB) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
         end else begin
            in_valid = 1'b0;
         end
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL b2b_complete leftover=%0d expected 0", sbq.size());
      end else begin
         $display("back_to_back C4 then 5A done");
      end
   endtask

   task automatic test_reset_midframe();
      do_reset(0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hC4;
      push_frame(8'hC4, 1'b0, 1);
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      #2 rst_b = 1'b0;
      #1;
      checks++;
      if ({so[0], sv[0], sl[0], bz[0], dn[0], rdy[0]} !== 6'b000001) begin
         errors++;
         $display("FAIL abort_state out/valid/last/busy/done/ready=%b%b%b%b%b%b expected 000001",
                  so[0], sv[0], sl[0], bz[0], dn[0], rdy[0]);
      end
      sbq.delete();
      @(negedge clk);
      #2 rst_b = 1'b1;
      @(negedge clk);
      checks++;
      if ({sv[0], dn[0], rdy[0]} !== 3'b001) begin
         errors++;
         $display("FAIL abort_idle valid/done/ready=%b%b%b expected 001", sv[0], dn[0], rdy[0]);
      end
      run_frame(0, 8'hFF, 1'b0, 1);
   endtask

`ifdef PISO_PARITY_EN
   task automatic test_parity();
      do_reset(0);
      run_frame(0, 8'hC4, 1'b0, 1);
      run_frame(0, 8'hC3, 1'b0, 1);
      do_reset(2);
      run_frame(2, 8'hC3, 1'b0, 3);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lsb();
      test_msb();
      test_div3();
      test_back_to_back();
      test_reset_midframe();
`ifdef PISO_PARITY_EN
      test_parity();
`endif
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
